// File: rtl/cdc_hs_receiver_if.sv
// Handshake bundle between the source domain, the receiver endpoint and the
// downstream consumer. With HS_RX_PARITY_EN defined, the bundle also carries
// the bundled parity bit and the captured parity-error flag.
interface cdc_hs_receiver_if #(
    parameter int DATA_W = 64
);
    logic              src_req;
    logic [DATA_W-1:0] src_data;
    logic              dest_ack;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef HS_RX_PARITY_EN
    logic              src_par;
    logic              out_perr;
`endif

    // Source and consumer side: drives the request, the data and the ready.
    modport master (
        output src_req,
        output src_data,
        input  dest_ack,
        input  out_valid,
        output out_ready,
        input  out_data
`ifdef HS_RX_PARITY_EN
        ,
        output src_par,
        input  out_perr
`endif
    );

    // Receiver endpoint side.
    modport slave (
        input  src_req,
        input  src_data,
        output dest_ack,
        output out_valid,
        input  out_ready,
        output out_data
`ifdef HS_RX_PARITY_EN
        ,
        input  src_par,
        output out_perr
`endif
    );
endinterface

// File: rtl/cdc_hs_receiver.sv
// Destination-clock endpoint of a 4-phase bundled-data clock-domain crossing.
// The request is synchronized through SYNC_STAGES flops (legal range 2..4);
// the data bus is captured directly because the source holds it stable
// until it sees dest_ack high. The captured word sits in a single-entry
// valid/ready buffer, and dest_ack is returned straight from a flop.
// Optional feature macro: HS_RX_PARITY_EN (adds src_par / out_perr).
module cdc_hs_receiver #(
    parameter int DATA_W      = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                dest_clk,
    input  logic                dest_rst,
    cdc_hs_receiver_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    state_t                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   valid_q, valid_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   capture;
    logic                   accept;
`ifdef HS_RX_PARITY_EN
    logic                   perr_q, perr_d;
`endif

    // Request synchronizer: the only path by which src_req enters this domain.
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.src_req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Next-state and buffer update: capture only from IDLE when the buffer is
    // free, which includes the case where the consumer drains it this edge.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
`ifdef HS_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        accept  = valid_q && bus.out_ready;
        capture = (state_q == IDLE) && req_s && (!valid_q || accept);

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            valid_d = 1'b1;
            data_d  = bus.src_data;
`ifdef HS_RX_PARITY_EN
            perr_d  = (^bus.src_data) ^ bus.src_par;
`endif
        end else if (accept) begin
            valid_d = 1'b0;
        end

        ack_d = (state_d == HOLD);
    end

    // Control and data registers; every register clears on reset.
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`ifdef HS_RX_PARITY_EN
    // Parity-error flag captured alongside the word and held with it.
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.out_perr = perr_q;
`endif

    assign bus.dest_ack  = ack_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_cdc_hs_receiver.sv
// Directed bench for cdc_hs_receiver: a SYNC_STAGES=2 instance for transfer,
// backpressure, streaming and reset cases, and a SYNC_STAGES=3 instance for
// the short-pulse case.
module tb_cdc_hs_receiver;

    logic clk;
    logic rst_a;
    logic rst_b;

    int checks;
    int errors;

    cdc_hs_receiver_if #(.DATA_W(64)) ifa ();
    cdc_hs_receiver_if #(.DATA_W(64)) ifb ();

    cdc_hs_receiver #(.DATA_W(64), .SYNC_STAGES(2)) dut_a (
        .dest_clk (clk),
        .dest_rst (rst_a),
        .bus      (ifa.slave)
    );

    cdc_hs_receiver #(.DATA_W(64), .SYNC_STAGES(3)) dut_b (
        .dest_clk (clk),
        .dest_rst (rst_b),
        .bus      (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [63:0] data;
        logic        rdy;
        logic        ack;
        logic        vld;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic req, input logic [63:0] data, input logic rdy,
                                input logic ack, input logic vld, input logic [63:0] dout);
        vec_t v;
        v.req = req; v.data = data; v.rdy = rdy;
        v.ack = ack; v.vld = vld; v.dout = dout;
        return v;
    endfunction

`ifdef HS_RX_PARITY_EN
    task automatic par_xfer(input logic [63:0] d, input logic p, input logic exp_perr, input string nm);
        int n;
        ifa.src_data  = d;
        ifa.src_par   = p;
        ifa.src_req   = 1'b1;
        ifa.out_ready = 1'b1;
        n = 0;
        while (!ifa.dest_ack && n < 20) begin step(); n++; end
        chk({nm, "_ack_rise"}, {63'd0, ifa.dest_ack}, 64'd1);
        chk({nm, "_data"}, ifa.out_data, d);
        chk({nm, "_perr"}, {63'd0, ifa.out_perr}, {63'd0, exp_perr});
        ifa.src_req = 1'b0;
        n = 0;
        while (ifa.dest_ack && n < 20) begin step(); n++; end
        chk({nm, "_ack_fall"}, {63'd0, ifa.dest_ack}, 64'd0);
        chk({nm, "_perr_held"}, {63'd0, ifa.out_perr}, {63'd0, exp_perr});
    endtask
`endif

    initial begin
        logic [63:0] DB;
        int widx, rx_cnt, pulses, phase, cyc;
        logic prev_ack, seen_ack, seen_vld;

        checks = 0;
        errors = 0;
        DB = 64'hDEADBEEF_01234567;

        // Basic transfer then backpressure on the SYNC_STAGES=2 instance.
        vecs[0]  = mk(1, DB,    1, 0, 0, 64'd0);
        vecs[1]  = mk(1, DB,    1, 0, 0, 64'd0);
        vecs[2]  = mk(1, DB,    1, 1, 1, DB);
        vecs[3]  = mk(0, DB,    1, 1, 0, DB);
        vecs[4]  = mk(0, DB,    1, 1, 0, DB);
        vecs[5]  = mk(0, DB,    1, 0, 0, DB);
        vecs[6]  = mk(0, DB,    1, 0, 0, DB);
        vecs[7]  = mk(1, 64'd1, 0, 0, 0, DB);
        vecs[8]  = mk(1, 64'd1, 0, 0, 0, DB);
        vecs[9]  = mk(1, 64'd1, 0, 1, 1, 64'd1);
        vecs[10] = mk(0, 64'd1, 0, 1, 1, 64'd1);
        vecs[11] = mk(0, 64'd1, 0, 1, 1, 64'd1);
        vecs[12] = mk(0, 64'd1, 0, 0, 1, 64'd1);
        vecs[13] = mk(1, 64'd2, 0, 0, 1, 64'd1);
        vecs[14] = mk(1, 64'd2, 0, 0, 1, 64'd1);
        vecs[15] = mk(1, 64'd2, 0, 0, 1, 64'd1);
        vecs[16] = mk(1, 64'd2, 0, 0, 1, 64'd1);
        vecs[17] = mk(1, 64'd2, 1, 1, 1, 64'd2);
        vecs[18] = mk(0, 64'd2, 0, 1, 1, 64'd2);
        vecs[19] = mk(0, 64'd2, 0, 1, 1, 64'd2);
        vecs[20] = mk(0, 64'd2, 1, 0, 0, 64'd2);
        vecs[21] = mk(0, 64'd2, 1, 0, 0, 64'd2);

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.src_req = 1'b0; ifa.src_data = '0; ifa.out_ready = 1'b0;
        ifb.src_req = 1'b0; ifb.src_data = '0; ifb.out_ready = 1'b1;
`ifdef HS_RX_PARITY_EN
        ifa.src_par = 1'b0;
        ifb.src_par = 1'b0;
`endif
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        chk("rst_ack_a",  {63'd0, ifa.dest_ack},  64'd0);
        chk("rst_vld_a",  {63'd0, ifa.out_valid}, 64'd0);
        chk("rst_data_a", ifa.out_data,           64'd0);
        chk("rst_ack_b",  {63'd0, ifb.dest_ack},  64'd0);
        chk("rst_vld_b",  {63'd0, ifb.out_valid}, 64'd0);

        for (int i = 0; i < 22; i++) begin
            ifa.src_req   = vecs[i].req;
            ifa.src_data  = vecs[i].data;
            ifa.out_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_ack", i),  {63'd0, ifa.dest_ack},  {63'd0, vecs[i].ack});
            chk($sformatf("vec%0d_vld", i),  {63'd0, ifa.out_valid}, {63'd0, vecs[i].vld});
            chk($sformatf("vec%0d_data", i), ifa.out_data,           vecs[i].dout);
        end

        // Sixteen back-to-back words with a randomly stalling consumer.
        widx = 0; rx_cnt = 0; pulses = 0; phase = 0; prev_ack = 1'b0;
        cyc = 0;
        while (cyc < 3000 && !(rx_cnt == 16 && widx == 16)) begin
            if (ifa.dest_ack && !prev_ack) pulses++;
            prev_ack = ifa.dest_ack;
            ifa.out_ready = 1'($urandom_range(0, 1));
            if (ifa.out_valid && ifa.out_ready) begin
                chk($sformatf("b2b_word%0d", rx_cnt), ifa.out_data, 64'(rx_cnt));
                rx_cnt++;
            end
            if (phase == 0 && widx < 16) begin
                ifa.src_data = 64'(widx);
                ifa.src_req  = 1'b1;
                phase = 1;
            end else if (phase == 1 && ifa.dest_ack) begin
                ifa.src_req = 1'b0;
                phase = 2;
            end else if (phase == 2 && !ifa.dest_ack) begin
                phase = 0;
                widx++;
            end
            step();
            cyc++;
        end
        chk("b2b_received", 64'(rx_cnt), 64'd16);
        chk("b2b_ack_pulses", 64'(pulses), 64'd16);
        ifa.out_ready = 1'b1;
        repeat (3) step();
        chk("b2b_drained", {63'd0, ifa.out_valid}, 64'd0);

        // Asynchronous reset while holding a word, then recapture.
        ifa.out_ready = 1'b0;
        ifa.src_data  = 64'hAAAA5555_AAAA5555;
        ifa.src_req   = 1'b1;
        repeat (3) step();
        chk("pre_rst_ack", {63'd0, ifa.dest_ack},  64'd1);
        chk("pre_rst_vld", {63'd0, ifa.out_valid}, 64'd1);
        #2 rst_a = 1'b1;
        #1;
        chk("async_rst_ack",  {63'd0, ifa.dest_ack},  64'd0);
        chk("async_rst_vld",  {63'd0, ifa.out_valid}, 64'd0);
        chk("async_rst_data", ifa.out_data,           64'd0);
        step();
        rst_a = 1'b0;
        step();
        step();
        chk("recap_e2_ack", {63'd0, ifa.dest_ack},  64'd0);
        chk("recap_e2_vld", {63'd0, ifa.out_valid}, 64'd0);
        step();
        chk("recap_e3_ack",  {63'd0, ifa.dest_ack},  64'd1);
        chk("recap_e3_vld",  {63'd0, ifa.out_valid}, 64'd1);
        chk("recap_e3_data", ifa.out_data,           64'hAAAA5555_AAAA5555);
        ifa.src_req   = 1'b0;
        ifa.out_ready = 1'b1;
        repeat (4) step();
        chk("recap_idle_ack", {63'd0, ifa.dest_ack}, 64'd0);

        // Short pulse between edges on the three-stage instance.
        seen_ack = 1'b0;
        seen_vld = 1'b0;
        #1 ifb.src_req = 1'b1;
        #2 ifb.src_req = 1'b0;
        for (int e = 0; e < 6; e++) begin
            step();
            seen_ack |= ifb.dest_ack;
            seen_vld |= ifb.out_valid;
        end
        chk("glitch_ack", {63'd0, seen_ack}, 64'd0);
        chk("glitch_vld", {63'd0, seen_vld}, 64'd0);

        ifb.src_data = 64'h0F0F0F0F_F0F0F0F0;
        ifb.src_req  = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk($sformatf("s3_rise_e%0d_ack", e), {63'd0, ifb.dest_ack}, (e == 4) ? 64'd1 : 64'd0);
        end
        chk("s3_vld",  {63'd0, ifb.out_valid}, 64'd1);
        chk("s3_data", ifb.out_data,           64'h0F0F0F0F_F0F0F0F0);
        ifb.src_req = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk($sformatf("s3_fall_e%0d_ack", e), {63'd0, ifb.dest_ack}, (e == 4) ? 64'd0 : 64'd1);
        end

`ifdef HS_RX_PARITY_EN
        par_xfer(64'h3, 1'b0, 1'b0, "par_even");
        par_xfer(64'h1, 1'b0, 1'b1, "par_err");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_hs_receiver.md
Name: cdc_hs_receiver

Overview:
Destination-clock endpoint of a 4-phase bundled-data clock-domain crossing. Safely carries multi-bit words that must not pass through a per-bit array synchronizer.
- Synchronizes the incoming request internally.
- Captures the source data bus, which is held stable by protocol.
- Presents the word on a valid/ready stream.
- Returns a registered acknowledge to the source domain.
Sits next to the per-bit synchronizers in the platform shell, receiving host-side control words into the core clock domain.

Parameters:
DATA_W, 64, width of transferred word
SYNC_STAGES, 2, flops in request synchronizer chain; legal range 2..4

Ports:
dest_clk  in  1  destination-domain clock; all state on rising edge
dest_rst  in  1  asynchronous, active-high reset; deassertion must already be synchronous to dest_clk
src_req  in  1  request from source domain; asynchronous to dest_clk
src_data  in  DATA_W  bundled data; stable from before src_req rises until the source observes dest_ack high
dest_ack  out  1  acknowledge to source domain; driven directly from a flop, no logic after it
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts word when out_valid && out_ready at a rising edge
out_data  out  DATA_W  captured word; constant while out_valid=1 and not accepted

Behaviour:
- Reset values: dest_ack=0, out_valid=0, out_data=0, all sync flops=0, FSM=IDLE.
- Synchronizer: req_s is the last of SYNC_STAGES flops clocked by dest_clk with async reset. The synchronizer is the only path from src_req; src_data is never resynchronized.
- FSM states: IDLE (ack=0), HOLD (ack=1).
- IDLE with req_s=1 and buffer free:
  - Buffer free means out_valid=0, or out_valid && out_ready in this cycle.
  - At the edge: out_data<=src_data, out_valid<=1, dest_ack<=1, go to HOLD.
- IDLE with req_s=1 and buffer not free: stay in IDLE, dest_ack stays 0, no capture. This is the backpressure path; the source stalls naturally.
- HOLD with req_s=1: stay; dest_ack=1.
- HOLD with req_s=0: dest_ack<=0, go to IDLE.
- No new capture is possible until req_s has been seen low (full 4-phase return to zero).
- Output buffer:
  - Single entry.
  - out_valid clears on accept unless a capture occurs in the same edge; in that case out_valid stays 1 with new data (accept and capture are simultaneous).
  - out_data changes only on capture.
- Latency, src_req high and settled before edge 1:
  - req_s high after edge SYNC_STAGES.
  - out_valid=1 and dest_ack=1 after edge SYNC_STAGES+1, provided the buffer is free.
  - dest_ack falls SYNC_STAGES+1 edges after src_req falls.
- Throughput: at most one word per full handshake. Source-domain round trip is excluded from this block's timing.
- Glitch/short pulse on src_req: a pulse that never reaches req_s has no effect. A pulse that reaches req_s is a legal request.
- Reset mid-operation:
  - Async clear of everything listed above; any pending out_data is lost.
  - If src_req is still high after reset release, a fresh capture occurs (duplicate word). The source domain must be reset together with this block.
- Timing constraints: src_req path gets an asynchronous false path or max-delay constraint to the first sync flop. src_data gets max-delay ≤ SYNC_STAGES destination periods. Both constraints are delivered with the block.

Optional Feature:
HS_RX_PARITY_EN
- Defined:
  - Adds input src_par (1 bit, even parity over src_data, bundled like data) and output out_perr (1 bit).
  - At capture, out_perr <= ^src_data ^ src_par; it is valid with out_valid and held like out_data.
  - Reset value 0.
  - The handshake completes regardless of parity result.
- Not defined: ports src_par and out_perr are absent; no parity logic.

Test Plan:
- Basic transfer, SYNC_STAGES=2, out_ready=1: src_data=64'hDEADBEEF_01234567, src_req rises before edge 1 -> out_valid and dest_ack =1 after edge 3, out_data=64'hDEADBEEF_01234567. src_req drops -> dest_ack=0 three edges later.
- Backpressure: out_ready=0, first word 64'h1 accepted; second handshake with 64'h2 -> dest_ack stays 0 and out_data stays 64'h1. Raise out_ready -> 64'h1 accepted and 64'h2 captured on the same edge, out_valid remains 1.
- Back-to-back 16 words 0..15 with random out_ready -> consumer receives 0..15 in order, no duplicates or drops, one dest_ack pulse per word.
- Reset mid-operation: assert dest_rst while in HOLD with out_valid=1 -> dest_ack, out_valid, out_data =0 immediately (asynchronously). Release with src_req held high -> recapture after SYNC_STAGES+1 edges.
- SYNC_STAGES=3, 1-cycle src_req glitch sampled low by the first flop -> no capture, dest_ack stays 0. Normal request -> capture after edge 4.
- HS_RX_PARITY_EN: src_data=64'h3, src_par=0 -> out_perr=0. src_data=64'h1, src_par=0 -> out_perr=1, dest_ack still completes.
